// File: rtl/rx_operand_assembler.sv
// rx_operand_assembler: collects UART bytes into operands A/B plus an opcode and publishes them
// atomically with a one-cycle done pulse. Define RX_CHECKSUM_EN to append a XOR checksum byte.
module rx_operand_assembler #(
    parameter int DBIT        = 8,
    parameter int NB_DATA     = 16,
    parameter int NB_OPERADOR = 6,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DBIT-1:0]        i_data,
    input  logic                   i_done_data,
    output logic [NB_DATA-1:0]     o_a,
    output logic [NB_DATA-1:0]     o_b,
    output logic [NB_OPERADOR-1:0] o_op,
    output logic                   o_rx_alu_done,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic                   o_chk_err
);

    localparam int NB_BYTES = NB_DATA / DBIT;
    localparam int BW       = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [BW-1:0] LAST_BYTE = BW'(NB_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_LAST_I);

`ifdef RX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_OP, GET_CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, GET_A, GET_B, GET_OP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [BW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [NB_DATA-1:0]     sh_a_q, sh_a_d;
    logic [NB_DATA-1:0]     sh_b_q, sh_b_d;
    logic [NB_OPERADOR-1:0] sh_op_q, sh_op_d;
    logic [NB_DATA-1:0]     a_q, a_d;
    logic [NB_DATA-1:0]     b_q, b_d;
    logic [NB_OPERADOR-1:0] op_q, op_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   load;
    logic                   last_byte;
`ifdef RX_CHECKSUM_EN
    logic [DBIT-1:0]        xor_q, xor_d;
    logic                   chk_err_q, chk_err_d;
`endif

    assign last_byte = (cnt_q == LAST_BYTE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sh_op_d   = sh_op_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        load      = 1'b0;
`ifdef RX_CHECKSUM_EN
        xor_d     = xor_q;
        chk_err_d = 1'b0;
        if (i_done_data) begin
            xor_d = xor_q ^ i_data;
        end
`endif

        case (state_q)
            IDLE: begin
                if (i_done_data) begin
                    sh_a_d[DBIT-1:0] = i_data;
                    if (NB_BYTES == 1) begin
                        state_d = GET_B;
                        cnt_d   = '0;
                    end else begin
                        state_d = GET_A;
                        cnt_d   = BW'(1);
                    end
                end
            end
            GET_A: begin
                if (i_done_data) begin
                    sh_a_d[int'(cnt_q) * DBIT +: DBIT] = i_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = GET_B;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            GET_B: begin
                if (i_done_data) begin
                    sh_b_d[int'(cnt_q) * DBIT +: DBIT] = i_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = GET_OP;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            GET_OP: begin
                if (i_done_data) begin
                    sh_op_d = i_data[NB_OPERADOR-1:0];
`ifdef RX_CHECKSUM_EN
                    state_d = GET_CHK;
`else
                    state_d = IDLE;
                    load    = 1'b1;
`endif
                end
            end
`ifdef RX_CHECKSUM_EN
            GET_CHK: begin
                // Frame is good when every byte, checksum included, XORs to zero.
                if (i_done_data) begin
                    state_d = IDLE;
                    xor_d   = '0;
                    if ((xor_q ^ i_data) == '0) begin
                        load = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            a_d    = sh_a_d;
            b_d    = sh_b_d;
            op_d   = sh_op_d;
            done_d = 1'b1;
        end

        // The limit edge is the one on which the idle count would reach TIMEOUT;
        // a strobe in that cycle is accepted instead.
        if (state_q != IDLE && !i_done_data) begin
            if (TIMEOUT != 0) begin
                if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b1;
`ifdef RX_CHECKSUM_EN
                    xor_d     = '0;
`endif
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            sh_op_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef RX_CHECKSUM_EN
            xor_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            sh_op_q   <= sh_op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
`ifdef RX_CHECKSUM_EN
            xor_q     <= xor_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    assign o_a           = a_q;
    assign o_b           = b_q;
    assign o_op          = op_q;
    assign o_rx_alu_done = done_q;
    assign o_timeout     = timeout_q;
    assign o_busy        = (state_q != IDLE);
`ifdef RX_CHECKSUM_EN
    assign o_chk_err     = chk_err_q;
`else
    assign o_chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_operand_assembler.sv
// Directed bench for rx_operand_assembler: a 16-bit-operand instance (TIMEOUT=100) and an
// 8-bit-operand instance, both checked against hand-computed values.
module tb_rx_operand_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  i_data = 8'h00;
    logic        i_done = 1'b0;
    logic [15:0] a, b;
    logic [5:0]  op;
    logic        done, busy, tmo, chk;

    logic [7:0]  d8 = 8'h00;
    logic        s8 = 1'b0;
    logic [7:0]  a8, b8;
    logic [5:0]  op8;
    logic        done8, busy8, tmo8, chk8;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  fr [6];
    int          fr_len = 0;

    rx_operand_assembler #(.DBIT(8), .NB_DATA(16), .NB_OPERADOR(6), .TIMEOUT(100)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_done_data(i_done),
        .o_a(a), .o_b(b), .o_op(op), .o_rx_alu_done(done), .o_busy(busy),
        .o_timeout(tmo), .o_chk_err(chk)
    );

    rx_operand_assembler #(.DBIT(8), .NB_DATA(8), .NB_OPERADOR(6), .TIMEOUT(100)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_data(d8), .i_done_data(s8),
        .o_a(a8), .o_b(b8), .o_op(op8), .o_rx_alu_done(done8), .o_busy(busy8),
        .o_timeout(tmo8), .o_chk_err(chk8)
    );

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        i_data = v;
        i_done = 1'b1;
    endtask

    task automatic drive8(input logic [7:0] v);
        @(negedge clk);
        d8 = v;
        s8 = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        i_done = 1'b0;
        s8     = 1'b0;
    endtask

    task automatic build_frame(input logic [15:0] fa, input logic [15:0] fb, input logic [7:0] fop);
        fr[0] = fa[7:0];
        fr[1] = fa[15:8];
        fr[2] = fb[7:0];
        fr[3] = fb[15:8];
        fr[4] = fop;
        fr[5] = fa[7:0] ^ fa[15:8] ^ fb[7:0] ^ fb[15:8] ^ fop;
`ifdef RX_CHECKSUM_EN
        fr_len = 6;
`else
        fr_len = 5;
`endif
    endtask

    task automatic send_frame(input logic [15:0] fa, input logic [15:0] fb, input logic [7:0] fop);
        build_frame(fa, fb, fop);
        for (int i = 0; i < fr_len; i++) drive(fr[i]);
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (a !== 16'h0 || b !== 16'h0 || op !== 6'h0) begin nerr++; $display("FAIL reset_ops: got a=%h b=%h op=%h expected 0", a, b, op); end
        nvec++; if ({done, busy, tmo, chk} !== 4'b0) begin nerr++; $display("FAIL reset_flags: got %b expected 0000", {done, busy, tmo, chk}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(8'h34);
        drive(8'h12);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b expected 1", busy); end
        drive(8'h78);
        drive(8'h56);
        drive(8'h20);
`ifdef RX_CHECKSUM_EN
        drive(8'h28);
`endif
        nvec++; if (done !== 1'b0 || a !== 16'h0) begin nerr++; $display("FAIL basic_early: got done=%b a=%h expected 0/0000", done, a); end
        idle();
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL basic_done: got %b expected 1", done); end
        nvec++; if (a !== 16'h1234 || b !== 16'h5678 || op !== 6'h20) begin nerr++; $display("FAIL basic_ops: got a=%h b=%h op=%h expected 1234 5678 20", a, b, op); end
        nvec++; if (busy !== 1'b0 || chk !== 1'b0) begin nerr++; $display("FAIL basic_idle: got busy=%b chk=%b expected 0 0", busy, chk); end
        idle();
        nvec++; if (done !== 1'b0 || a !== 16'h1234) begin nerr++; $display("FAIL basic_pulse: got done=%b a=%h expected 0 1234", done, a); end
    endtask

    task automatic test_opcode_mask();
        send_frame(16'h0102, 16'h0304, 8'hE5);
        idle();
        nvec++; if (op !== 6'h25 || a !== 16'h0102 || b !== 16'h0304 || done !== 1'b1) begin nerr++; $display("FAIL opcode_mask: got op=%h a=%h b=%h done=%b expected 25 0102 0304 1", op, a, b, done); end
    endtask

    task automatic test_back_to_back();
        send_frame(16'h1234, 16'h5678, 8'h20);
        build_frame(16'hABCD, 16'h0F0E, 8'hFF);
        drive(fr[0]);
        nvec++; if (done !== 1'b1 || a !== 16'h1234) begin nerr++; $display("FAIL b2b_first: got done=%b a=%h expected 1 1234", done, a); end
        for (int i = 1; i < fr_len; i++) drive(fr[i]);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL b2b_gap: got done=%b expected 0", done); end
        idle();
        nvec++; if (done !== 1'b1 || a !== 16'hABCD || b !== 16'h0F0E || op !== 6'h3F) begin nerr++; $display("FAIL b2b_second: got done=%b a=%h b=%h op=%h expected 1 ABCD 0F0E 3F", done, a, b, op); end
        idle();
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL b2b_pulse: got done=%b expected 0", done); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        drive(8'h34);
        drive(8'h12);
        for (int i = 0; i < 100; i++) begin
            idle();
            if (tmo !== 1'b0 || busy !== 1'b1) bad++;
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL timeout_early: got %0d bad cycles expected 0", bad); end
        idle();
        nvec++; if (tmo !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL timeout_fire: got tmo=%b busy=%b expected 1 0", tmo, busy); end
        nvec++; if (a !== 16'hABCD || b !== 16'h0F0E || op !== 6'h3F || done !== 1'b0) begin nerr++; $display("FAIL timeout_hold: got a=%h b=%h op=%h done=%b expected ABCD 0F0E 3F 0", a, b, op, done); end
        idle();
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL timeout_pulse: got %b expected 0", tmo); end
        send_frame(16'h1234, 16'h5678, 8'h20);
        idle();
        nvec++; if (done !== 1'b1 || a !== 16'h1234 || b !== 16'h5678 || op !== 6'h20) begin nerr++; $display("FAIL timeout_next: got done=%b a=%h b=%h op=%h expected 1 1234 5678 20", done, a, b, op); end
    endtask

    task automatic test_limit();
        build_frame(16'h2211, 16'h4433, 8'h07);
        drive(fr[0]);
        drive(fr[1]);
        repeat (99) idle();
        for (int i = 2; i < fr_len; i++) begin
            drive(fr[i]);
            if (i == 3) begin
                nvec++; if (tmo !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL limit_accept: got tmo=%b busy=%b expected 0 1", tmo, busy); end
            end
        end
        idle();
        nvec++; if (done !== 1'b1 || a !== 16'h2211 || b !== 16'h4433 || op !== 6'h07) begin nerr++; $display("FAIL limit_frame: got done=%b a=%h b=%h op=%h expected 1 2211 4433 07", done, a, b, op); end
    endtask

    task automatic test_mid_reset();
        drive(8'h99);
        drive(8'h88);
        drive(8'h77);
        @(negedge clk);
        i_done = 1'b0;
        rst    = 1'b1;
        #1;
        nvec++; if (a !== 16'h0 || b !== 16'h0 || op !== 6'h0 || busy !== 1'b0) begin nerr++; $display("FAIL midreset: got a=%h b=%h op=%h busy=%b expected 0 0 0 0", a, b, op, busy); end
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'hBEEF, 16'hCAFE, 8'h15);
        idle();
        nvec++; if (done !== 1'b1 || a !== 16'hBEEF || b !== 16'hCAFE || op !== 6'h15) begin nerr++; $display("FAIL midreset_next: got done=%b a=%h b=%h op=%h expected 1 BEEF CAFE 15", done, a, b, op); end
    endtask

`ifdef RX_CHECKSUM_EN
    task automatic test_checksum();
        drive(8'h34); drive(8'h12); drive(8'h78); drive(8'h56); drive(8'h20); drive(8'h28);
        idle();
        nvec++; if (done !== 1'b1 || chk !== 1'b0 || a !== 16'h1234 || b !== 16'h5678) begin nerr++; $display("FAIL chk_good: got done=%b chk=%b a=%h b=%h expected 1 0 1234 5678", done, chk, a, b); end
        send_frame(16'hABCD, 16'h0F0E, 8'h3F);
        drive(8'h34); drive(8'h12); drive(8'h78); drive(8'h56); drive(8'h20); drive(8'h29);
        idle();
        nvec++; if (chk !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL chk_bad: got chk=%b done=%b expected 1 0", chk, done); end
        nvec++; if (a !== 16'hABCD || b !== 16'h0F0E || op !== 6'h3F) begin nerr++; $display("FAIL chk_hold: got a=%h b=%h op=%h expected ABCD 0F0E 3F", a, b, op); end
        idle();
        nvec++; if (chk !== 1'b0) begin nerr++; $display("FAIL chk_pulse: got %b expected 0", chk); end
    endtask
`endif

    task automatic test_nb8();
        drive8(8'hAA);
        drive8(8'h55);
        drive8(8'h03);
`ifdef RX_CHECKSUM_EN
        drive8(8'hFC);
`endif
        nvec++; if (done8 !== 1'b0 || busy8 !== 1'b1) begin nerr++; $display("FAIL nb8_pending: got done=%b busy=%b expected 0 1", done8, busy8); end
        idle();
        nvec++; if (done8 !== 1'b1 || a8 !== 8'hAA || b8 !== 8'h55 || op8 !== 6'h03) begin nerr++; $display("FAIL nb8_frame: got done=%b a=%h b=%h op=%h expected 1 AA 55 03", done8, a8, b8, op8); end
        idle();
        nvec++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin nerr++; $display("FAIL nb8_pulse: got done=%b busy=%b expected 0 0", done8, busy8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_opcode_mask();
        test_back_to_back();
        test_timeout();
        test_limit();
        test_mid_reset();
`ifdef RX_CHECKSUM_EN
        test_checksum();
`endif
        test_nb8();
        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rx_operand_assembler.md
Name: rx_operand_assembler

Overview:
- Parametrised successor to the UART-RX-to-ALU front end.
- Gathers bytes from the UART receiver into two multi-byte operands (A, B) and one opcode, then presents them atomically to the ALU with a one-cycle done pulse.
- Adds features the previous generation lacks: configurable operand width, an inter-byte timeout that discards stale partial frames, a busy flag, and an optional checksum byte.

Parameters:
- DBIT, 8, UART data byte width.
- NB_DATA, 16, operand width for A and B. Must be a multiple of DBIT. NB_BYTES = NB_DATA/DBIT.
- NB_OPERADOR, 6, opcode width. Must be ≤ DBIT.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame. 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_data  in  DBIT  received byte; valid only while i_done_data=1.
- i_done_data  in  1  one-cycle strobe from UART RX; byte accepted on every cycle it is high.
- o_a  out  NB_DATA  operand A.
- o_b  out  NB_DATA  operand B.
- o_op  out  NB_OPERADOR  opcode.
- o_rx_alu_done  out  1  one-cycle pulse: new o_a/o_b/o_op valid.
- o_busy  out  1  partial frame in progress (state ≠ IDLE).
- o_timeout  out  1  one-cycle pulse: partial frame discarded by timeout.
- o_chk_err  out  1  one-cycle pulse: checksum mismatch. Tied 0 when the macro is off.

Behaviour:
- Reset (async, high): state=IDLE; byte counter=0; timeout counter=0. o_a, o_b, o_op = 0. All pulse outputs = 0. o_busy = 0. Asserting reset mid-frame discards the partial frame.
- Frame order: A bytes, then B bytes, then one opcode byte, then the checksum byte (macro only). Operands are little-endian: byte k lands in bits [k*DBIT +: DBIT].
- Opcode: o_op = opcode byte[NB_OPERADOR-1:0]; upper bits ignored.
- Assembly uses internal shadow registers. o_a, o_b and o_op hold their previous values until frame completion, then all three load in the same edge.
- FSM states: IDLE, GET_A, GET_B, GET_OP, GET_CHK (macro only).
  - IDLE: strobe stores A byte 0. Go to GET_A with count=1, or to GET_B if NB_BYTES=1.
  - GET_A / GET_B: each strobe stores byte[count] and increments count. After byte NB_BYTES-1, clear count and advance to the next state.
  - GET_OP: strobe stores the opcode. Without macro: frame complete → IDLE. With macro: → GET_CHK.
  - GET_CHK: strobe completes the frame → IDLE (pass or fail).
- Completion latency: the final byte's strobe is at edge N. At edge N the outputs load and o_rx_alu_done is registered high. It is visible during cycle N+1, for exactly one cycle.
- Back-to-back strobes on consecutive cycles are fully supported. A strobe in the cycle right after completion starts a new frame; done still pulses once.
- Timeout:
  - The counter clears on every accepted byte and in IDLE, and increments every cycle while not IDLE.
  - When it reaches TIMEOUT, with no strobe that cycle: discard the partial frame, go to IDLE, clear counters, pulse o_timeout for one cycle. o_a/o_b/o_op are unchanged.
  - Strobe in the same cycle the limit is reached: the strobe wins, the byte is accepted, and no timeout fires.
  - TIMEOUT=0: counter inactive; o_timeout is never asserted.
- o_busy is combinational from the state: 1 in any state except IDLE.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - A running XOR of every frame byte is kept.
  - A checksum byte follows the opcode; the frame is valid if the XOR of all bytes including the checksum is 0.
  - Valid: outputs load and o_rx_alu_done pulses.
  - Invalid: no output load, no done pulse; o_chk_err pulses for one cycle at the same latency as done. State → IDLE.
  - The running XOR clears on reset, on timeout and on frame completion.
- Undefined: no GET_CHK state and no XOR logic; o_chk_err constant 0.

Test Plan:
- NB_DATA=16, no macro; strobe bytes 34,12,78,56,20 (hex) on separate cycles → one cycle after the 5th strobe: o_a=1234, o_b=5678, o_op=20, o_rx_alu_done high for one cycle. o_busy is 1 from after byte 1 until completion.
- Opcode byte E5 with NB_OPERADOR=6 → o_op=25. Two full frames strobed on consecutive cycles with no gap → two done pulses; second operands correct.
- TIMEOUT=100: send 34,12, then 100 idle cycles → o_timeout single pulse, state IDLE, o_a/o_b/o_op unchanged from the previous frame. A following full frame assembles correctly. A byte arriving exactly at the limit cycle is accepted, with no timeout.
- Assert i_rst for one cycle after 3 bytes of a frame → all outputs 0, o_busy=0 immediately (async). The next full frame yields correct values.
- RX_CHECKSUM_EN: bytes 34,12,78,56,20, checksum 28 → done pulse, correct outputs. Same bytes with checksum 29 → o_chk_err pulse, no done, outputs unchanged.
- NB_DATA=8: bytes AA,55,03 → o_a=AA, o_b=55, o_op=03, done one cycle after the 3rd strobe.
